// File: rtl/activation_stack_sequencer.sv
// Sequences one training sample through the activation stack: writes activations 0..N, then reads pairs from N-1 down to 0.
// Streams pass through combinationally (zero latency). Backpressure comes from stack_wr_ready and stack_rd_addr_ready.
// Abort wins over everything: it lowers all readies and valids in its cycle and returns to IDLE.
module activation_stack_sequencer #(
  parameter int NEURON_NUM       = 6,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int STACK_ADDR_WIDTH = 10,
  parameter int LAYER_MAX        = 3,
  parameter int LAYER_WIDTH      = $clog2(LAYER_MAX + 1),
  localparam int STACK_WIDTH     = NEURON_NUM * ACTIVATION_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LAYER_WIDTH-1:0]      layer_count,
  input  logic [STACK_WIDTH-1:0]      in_act_data,
  input  logic                        in_act_valid,
  output logic                        in_act_ready,
  input  logic [STACK_WIDTH-1:0]      fwd_act_data,
  input  logic                        fwd_act_valid,
  output logic                        fwd_act_ready,
  output logic [STACK_WIDTH-1:0]      stack_wr_data,
  output logic                        stack_wr_data_valid,
  output logic                        stack_wr_addr_valid,
  output logic [STACK_ADDR_WIDTH-1:0] stack_wr_addr,
  input  logic                        stack_wr_ready,
  output logic [STACK_ADDR_WIDTH-1:0] stack_rd_addr,
  output logic                        stack_rd_addr_valid,
  input  logic                        stack_rd_addr_ready,
  input  logic                        bwd_rd_req,
  output logic [LAYER_WIDTH-1:0]      bwd_layer,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {IDLE, WR_INPUT, WR_FWD, RD_BWD, DONE} state_t;

  localparam logic [LAYER_WIDTH-1:0] LAYER_MAX_L = LAYER_WIDTH'(LAYER_MAX);
  localparam logic [LAYER_WIDTH-1:0] ONE_L       = LAYER_WIDTH'(1);
  localparam int                     PAD_W       = STACK_ADDR_WIDTH - LAYER_WIDTH;

  state_t                 state;
  logic [LAYER_WIDTH-1:0] wr_ptr;
  logic [LAYER_WIDTH-1:0] rd_ptr;
  logic [LAYER_WIDTH-1:0] n_layers;
  logic [LAYER_WIDTH-1:0] layer_count_eff;

  logic in_sel;
  logic fwd_sel;
  logic rd_sel;
  logic wr_vld;
  logic wr_hs;
  logic rd_vld;
  logic rd_hs;

  assign in_sel  = (state == WR_INPUT);
  assign fwd_sel = (state == WR_FWD);
  assign rd_sel  = (state == RD_BWD);

  // Abort masks every valid so neither stream nor stack sees a handshake in that cycle.
  assign wr_vld = !abort && ((in_sel && in_act_valid) || (fwd_sel && fwd_act_valid));
  assign wr_hs  = wr_vld && stack_wr_ready;
  assign rd_vld = !abort && rd_sel && bwd_rd_req;
  assign rd_hs  = rd_vld && stack_rd_addr_ready;

  // Zero or out-of-range layer counts fall back to the deepest supported network.
  assign layer_count_eff = (layer_count == '0 || int'(layer_count) > LAYER_MAX) ? LAYER_MAX_L : layer_count;

  assign stack_wr_data       = in_sel ? in_act_data : (fwd_sel ? fwd_act_data : '0);
  assign stack_wr_data_valid = wr_vld;
  assign stack_wr_addr_valid = wr_vld;
  assign stack_wr_addr       = (in_sel || fwd_sel) ? {{PAD_W{1'b0}}, wr_ptr} : '0;
  assign in_act_ready        = !abort && in_sel && stack_wr_ready;
  assign fwd_act_ready       = !abort && fwd_sel && stack_wr_ready;

  assign stack_rd_addr       = rd_sel ? {{PAD_W{1'b0}}, rd_ptr} : '0;
  assign stack_rd_addr_valid = rd_vld;
  assign bwd_layer           = rd_sel ? rd_ptr : '0;

  assign busy = (state != IDLE);
  assign done = (state == DONE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      n_layers <= LAYER_MAX_L;
    end else if (abort) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_layers <= layer_count_eff;
            wr_ptr   <= '0;
            state    <= WR_INPUT;
          end
        end
        WR_INPUT: begin
          if (wr_hs) begin
            wr_ptr <= ONE_L;
            state  <= WR_FWD;
          end
        end
        WR_FWD: begin
          // The last forward write leaves wr_ptr at n_layers so it never passes LAYER_MAX.
          if (wr_hs) begin
            if (wr_ptr == n_layers) begin
              rd_ptr <= n_layers - ONE_L;
              state  <= RD_BWD;
            end else begin
              wr_ptr <= wr_ptr + ONE_L;
            end
          end
        end
        RD_BWD: begin
          if (rd_hs) begin
            if (rd_ptr == '0) state <= DONE;
            else              rd_ptr <= rd_ptr - ONE_L;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_stack_sequencer.sv
// Randomized bench for activation_stack_sequencer, checked every cycle against a phase/count model.
module tb_activation_stack_sequencer;

  localparam int NN  = 6;
  localparam int AW  = 8;
  localparam int SAW = 10;
  localparam int LM  = 3;
  localparam int LW  = 2;
  localparam int SW  = NN * AW;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic [LW-1:0]  layer_count;
  logic [SW-1:0]  in_act_data;
  logic           in_act_valid;
  logic           in_act_ready;
  logic [SW-1:0]  fwd_act_data;
  logic           fwd_act_valid;
  logic           fwd_act_ready;
  logic [SW-1:0]  stack_wr_data;
  logic           stack_wr_data_valid;
  logic           stack_wr_addr_valid;
  logic [SAW-1:0] stack_wr_addr;
  logic           stack_wr_ready;
  logic [SAW-1:0] stack_rd_addr;
  logic           stack_rd_addr_valid;
  logic           stack_rd_addr_ready;
  logic           bwd_rd_req;
  logic [LW-1:0]  bwd_layer;
  logic           busy;
  logic           done;

  activation_stack_sequencer #(
    .NEURON_NUM(NN), .ACTIVATION_WIDTH(AW), .STACK_ADDR_WIDTH(SAW), .LAYER_MAX(LM), .LAYER_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .layer_count(layer_count),
    .in_act_data(in_act_data), .in_act_valid(in_act_valid), .in_act_ready(in_act_ready),
    .fwd_act_data(fwd_act_data), .fwd_act_valid(fwd_act_valid), .fwd_act_ready(fwd_act_ready),
    .stack_wr_data(stack_wr_data), .stack_wr_data_valid(stack_wr_data_valid),
    .stack_wr_addr_valid(stack_wr_addr_valid), .stack_wr_addr(stack_wr_addr),
    .stack_wr_ready(stack_wr_ready), .stack_rd_addr(stack_rd_addr),
    .stack_rd_addr_valid(stack_rd_addr_valid), .stack_rd_addr_ready(stack_rd_addr_ready),
    .bwd_rd_req(bwd_rd_req), .bwd_layer(bwd_layer), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_layers(input int lc);
    return (lc == 0 || lc > LM) ? LM : lc;
  endfunction

  // Model: phase 0 idle, 1 writing, 2 reading, 3 done; progress kept as write/read counts.
  int m_phase = 0;
  int m_n = LM;
  int m_w = 0;
  int m_r = 0;

  int wr_log[$];
  int wr_cyc[$];
  int rd_log[$];
  int rd_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;

  logic          e_first, e_src_vld, e_wv, e_ir, e_fr, e_rv;
  logic [SW-1:0] e_src;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_w = 0; m_r = 0; m_n = LM;
      chk("rst_busy", busy, 0);
      chk("rst_wr_vld", stack_wr_data_valid, 0);
      chk("rst_rd_vld", stack_rd_addr_valid, 0);
    end else begin
      if (stack_wr_data_valid && stack_wr_ready) begin wr_log.push_back(int'(stack_wr_addr)); wr_cyc.push_back(cyc); end
      if (stack_rd_addr_valid && stack_rd_addr_ready) begin rd_log.push_back(int'(stack_rd_addr)); rd_cyc.push_back(cyc); end
      if (done) begin done_cnt++; done_cyc = cyc; end

      e_first   = (m_w == 0);
      e_src_vld = e_first ? in_act_valid : fwd_act_valid;
      e_src     = e_first ? in_act_data : fwd_act_data;
      e_wv      = (m_phase == 1) && e_src_vld && !abort;
      e_ir      = (m_phase == 1) && e_first && stack_wr_ready && !abort;
      e_fr      = (m_phase == 1) && !e_first && stack_wr_ready && !abort;
      e_rv      = (m_phase == 2) && bwd_rd_req && !abort;

      chk("busy", busy, m_phase != 0);
      chk("done", done, (m_phase == 3) && !abort);
      chk("wr_data_valid", stack_wr_data_valid, e_wv);
      chk("wr_addr_valid", stack_wr_addr_valid, e_wv);
      chk("in_ready", in_act_ready, e_ir);
      chk("fwd_ready", fwd_act_ready, e_fr);
      chk("rd_valid", stack_rd_addr_valid, e_rv);
      if (e_wv) begin
        chk("wr_addr", stack_wr_addr, m_w);
        chk("wr_data", stack_wr_data, e_src);
      end
      if (m_phase == 2) begin
        chk("rd_addr", stack_rd_addr, m_n - 1 - m_r);
        chk("bwd_layer", bwd_layer, m_n - 1 - m_r);
      end

      if (abort) begin
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (start) begin m_phase = 1; m_n = eff_layers(int'(layer_count)); m_w = 0; end
          1: if (e_src_vld && stack_wr_ready) begin
               m_w++;
               if (m_w == m_n + 1) begin m_phase = 2; m_r = 0; end
             end
          2: if (bwd_rd_req && stack_rd_addr_ready) begin
               m_r++;
               if (m_r == m_n) m_phase = 3;
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic coin(input int stall_pct);
    return $urandom_range(99) >= stall_pct;
  endfunction

  task automatic rand_inputs(input int stall_pct, input bit hold_start);
    in_act_valid        = coin(stall_pct);
    fwd_act_valid       = coin(stall_pct);
    stack_wr_ready      = coin(stall_pct);
    bwd_rd_req          = coin(stall_pct);
    stack_rd_addr_ready = coin(stall_pct);
    in_act_data         = {$urandom, $urandom};
    fwd_act_data        = {$urandom, $urandom};
    start               = hold_start ? 1'($urandom_range(1)) : 1'b0;
    layer_count         = LW'($urandom_range(3));
  endtask

  // Runs one full sample; returns the first cycle seen idle again.
  task automatic run_sample(input int lc, input int stall_pct, input bit hold_start, output int idle_cyc);
    bit ended;
    wr_log.delete(); wr_cyc.delete(); rd_log.delete(); rd_cyc.delete();
    ended = 0;
    idle_cyc = 0;
    rand_inputs(stall_pct, 0);
    start = 1'b1;
    layer_count = LW'(lc);
    tick();
    for (int i = 0; i < 1000 && !ended; i++) begin
      rand_inputs(stall_pct, hold_start);
      tick();
      if (!busy) begin ended = 1; idle_cyc = cyc; end
    end
    start = 1'b0;
    if (!ended) chk("sample_timeout", 1, 0);
  endtask

  task automatic check_sequences(input string tag, input int n);
    chk({tag, "_wr_count"}, wr_log.size(), n + 1);
    chk({tag, "_rd_count"}, rd_log.size(), n);
    for (int i = 0; i < wr_log.size() && i <= n; i++) chk({tag, "_wr_seq"}, wr_log[i], i);
    for (int i = 0; i < rd_log.size() && i < n; i++) chk({tag, "_rd_seq"}, rd_log[i], n - 1 - i);
  endtask

  task automatic all_ready();
    in_act_valid = 1; fwd_act_valid = 1; stack_wr_ready = 1; bwd_rd_req = 1; stack_rd_addr_ready = 1;
  endtask

  int idle_c;
  int d0;
  int exp_w[4] = '{0, 1, 2, 3};
  int exp_r[3] = '{2, 1, 0};

  initial begin
    rst_n = 0; start = 0; abort = 0; layer_count = '0;
    in_act_data = '0; in_act_valid = 0; fwd_act_data = '0; fwd_act_valid = 0;
    stack_wr_ready = 0; stack_rd_addr_ready = 0; bwd_rd_req = 0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_in_ready", in_act_ready, 0);
    chk("reset_wr_addr", stack_wr_addr, 0);
    chk("reset_rd_addr", stack_rd_addr, 0);
    chk("reset_bwd_layer", bwd_layer, 0);
    rst_n = 1;
    repeat (2) tick();

    // Nominal N=3 with no stalls.
    d0 = done_cnt;
    run_sample(3, 0, 0, idle_c);
    for (int i = 0; i < 4; i++) chk("nom_wr_addr", (wr_log.size() > i) ? wr_log[i] : -1, exp_w[i]);
    for (int i = 0; i < 3; i++) chk("nom_rd_addr", (rd_log.size() > i) ? rd_log[i] : -1, exp_r[i]);
    chk("nom_done_count", done_cnt - d0, 1);
    if (wr_cyc.size() == 4 && rd_cyc.size() == 3) begin
      chk("nom_wr_back_to_back", wr_cyc[3] - wr_cyc[0], 3);
      chk("nom_rd_after_wr", rd_cyc[0] - wr_cyc[3], 1);
      chk("nom_done_after_rd0", done_cyc - rd_cyc[2], 1);
    end else begin
      chk("nom_log_sizes", 0, 1);
    end
    chk("nom_idle_after_done", idle_c - done_cyc, 1);

    // Layer-count boundaries.
    run_sample(0, 30, 0, idle_c);
    check_sequences("lc0", 3);
    run_sample(1, 0, 0, idle_c);
    check_sequences("lc1", 1);

    // Abort in WR_FWD after address 1 has been written.
    all_ready();
    start = 1; layer_count = 2'd3;
    tick();
    start = 0;
    wr_log.delete();
    for (int i = 0; i < 20 && wr_log.size() < 2; i++) tick();
    chk("abort_reached_wr1", wr_log.size(), 2);
    d0 = done_cnt;
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_act_ready, 0);
    chk("abort_fwd_ready", fwd_act_ready, 0);
    chk("abort_wr_valid", stack_wr_data_valid, 0);
    chk("abort_rd_valid", stack_rd_addr_valid, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    run_sample(2, 20, 0, idle_c);
    check_sequences("after_abort", 2);

    // start held randomly through the sample, and start with abort in IDLE.
    run_sample(3, 25, 1, idle_c);
    check_sequences("start_busy", 3);
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    chk("start_abort_idle", busy, 0);
    tick();
    chk("start_abort_idle2", busy, 0);

    // Asynchronous reset in the middle of the read phase.
    all_ready();
    start = 1; layer_count = 2'd3;
    tick();
    start = 0;
    rd_log.delete();
    for (int i = 0; i < 20 && rd_log.size() < 1; i++) tick();
    chk("rst_reached_rd", rd_log.size(), 1);
    #1 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd_valid", stack_rd_addr_valid, 0);
    chk("arst_rd_addr", stack_rd_addr, 0);
    chk("arst_bwd_layer", bwd_layer, 0);
    chk("arst_in_ready", in_act_ready, 0);
    chk("arst_done", done, 0);
    tick();
    tick();
    #1 rst_n = 1;
    repeat (3) tick();
    chk("post_rst_idle", busy, 0);

    // Randomized samples with backpressure.
    for (int s = 0; s < 30; s++) begin
      int lc;
      lc = $urandom_range(3);
      run_sample(lc, $urandom_range(60), 1'($urandom_range(1)), idle_c);
      check_sequences("rand", eff_layers(lc));
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
